// File: rtl/rx_link_ctrl.sv
// rx_link_ctrl: qualifies packets from the UART receiver, buffers good ones in a
// two-entry FIFO for game logic, and resyncs the receiver when the link looks unhealthy.
module rx_link_ctrl #(
   parameter logic [7:0] HDR            = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 13_000_000,
   parameter int         RESYNC_CYCLES  = 1024,
   parameter int         ERR_LIMIT      = 4
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic [161:0] pkt_in,
   input  logic         pkt_ready_in,
   output logic         rx_rst_out,
   output logic [161:0] pkt_out,
   output logic         pkt_valid_out,
   input  logic         pkt_ack_in,
   output logic         link_up_out,
   output logic [7:0]   drop_count_out,
   output logic [7:0]   err_count_out
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = $clog2(RESYNC_CYCLES + 1);
   localparam int EW = $clog2(ERR_LIMIT + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] RESYNC_LAST  = RW'(RESYNC_CYCLES - 1);
   localparam logic [EW-1:0] ERR_MAX      = EW'(ERR_LIMIT);

   typedef enum logic [1:0] {
      LINK_DOWN = 2'd0,
      LINK_UP   = 2'd1,
      RESYNC    = 2'd2
   } state_t;

   state_t        state, state_next;
   logic [TW-1:0] timeout_cnt, timeout_next;
   logic [RW-1:0] resync_cnt, resync_next;
   logic [EW-1:0] consec_err, consec_next;
   logic [161:0]  head, tail;
   logic [1:0]    count;
   logic          link_up;
   logic [7:0]    drop_cnt, err_cnt;

   logic strobe, good, bad, pop, push, drop;

   // Strobes are ignored entirely while the receiver is being reset.
   assign strobe = pkt_ready_in && (state != RESYNC);
   assign good   = strobe && (pkt_in[161:154] == HDR) && ~^pkt_in;
   assign bad    = strobe && !good;
   assign pop    = pkt_ack_in && (count != 2'd0);
   assign push   = good && ((count != 2'd2) || pop);
   assign drop   = good && (count == 2'd2) && !pop;

   always_comb begin
      state_next   = state;
      timeout_next = timeout_cnt;
      resync_next  = resync_cnt;
      consec_next  = consec_err;
      if (good)
         consec_next = '0;
      else if (bad && consec_err != ERR_MAX)
         consec_next = consec_err + 1'b1;
      case (state)
         LINK_DOWN: begin
            timeout_next = '0;
            if (bad && consec_next == ERR_MAX)
               state_next = RESYNC;
            else if (good)
               state_next = LINK_UP;
         end
         LINK_UP: begin
            timeout_next = good ? '0 : timeout_cnt + 1'b1;
            if ((bad && consec_next == ERR_MAX) || (!good && timeout_cnt == TIMEOUT_LAST))
               state_next = RESYNC;
         end
         RESYNC: begin
            if (resync_cnt == RESYNC_LAST)
               state_next = LINK_DOWN;
            else
               resync_next = resync_cnt + 1'b1;
         end
         default: state_next = LINK_DOWN;
      endcase
      // Entering resync starts the hold window with clean health counters.
      if (state_next == RESYNC && state != RESYNC) begin
         timeout_next = '0;
         consec_next  = '0;
         resync_next  = '0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state       <= LINK_DOWN;
         timeout_cnt <= '0;
         resync_cnt  <= '0;
         consec_err  <= '0;
         link_up     <= 1'b0;
      end else begin
         state       <= state_next;
         timeout_cnt <= timeout_next;
         resync_cnt  <= resync_next;
         consec_err  <= consec_next;
         link_up     <= (state_next == LINK_UP);
      end
   end

   // Pop happens before push, so a full FIFO with an ack still takes a new packet.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head  <= '0;
         tail  <= '0;
         count <= 2'd0;
      end else begin
         case ({pop, push})
            2'b10: begin
               if (count == 2'd2)
                  head <= tail;
               count <= count - 1'b1;
            end
            2'b01: begin
               if (count == 2'd0)
                  head <= pkt_in;
               else
                  tail <= pkt_in;
               count <= count + 1'b1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head <= pkt_in;
               end else begin
                  head <= tail;
                  tail <= pkt_in;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         drop_cnt <= 8'd0;
         err_cnt  <= 8'd0;
      end else begin
         if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
         if (bad && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end

   assign rx_rst_out     = (state == RESYNC);
   assign pkt_out        = head;
   assign pkt_valid_out  = (count != 2'd0);
   assign link_up_out    = link_up;
   assign drop_count_out = drop_cnt;
   assign err_count_out  = err_cnt;

endmodule
